// File: rtl/ultrasonic_sensor_uart_receiver_pkg.sv
// Shared constants for the ultrasonic sensor UART path: rx state encodings,
// ASCII command bytes and baud defaults common to the receiver and transmitter.
package ultrasonic_sensor_uart_receiver_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;
    localparam int HALF_BIT_DEF     = 2604;
    localparam int DATA_BITS_P      = 8;
    localparam int CNT_W            = 13;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

    localparam logic [7:0] cmd_cm_p      = 8'h63;
    localparam logic [7:0] cmd_cm_uc_p   = 8'h43;
    localparam logic [7:0] cmd_inch_p    = 8'h69;
    localparam logic [7:0] cmd_inch_uc_p = 8'h49;
    localparam logic [7:0] cmd_meas_p    = 8'h6D;
    localparam logic [7:0] cmd_meas_uc_p = 8'h4D;

    typedef enum logic [1:0] {CMD_NONE, CMD_CM, CMD_INCH, CMD_MEAS} cmd_e;

    function automatic cmd_e decode_cmd(input logic [7:0] b);
        case (b)
            cmd_cm_p,   cmd_cm_uc_p:   return CMD_CM;
            cmd_inch_p, cmd_inch_uc_p: return CMD_INCH;
            cmd_meas_p, cmd_meas_uc_p: return CMD_MEAS;
            default:                   return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ultrasonic_sensor_uart_receiver_bit_sync.sv
// Two-flop synchronizer for the asynchronous Rx line; both flops reset to
// the idle-high level so reset never looks like a start bit.
module uart_rx_bit_sync (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ultrasonic_sensor_uart_receiver.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with ASCII
// command decode for the cm/inch unit select and measure-request pulse.
module ultrasonic_sensor_uart_receiver
    import ultrasonic_sensor_uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT_P = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT_P     = HALF_BIT_DEF
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Rx_i,
    output logic [7:0] Data_o,
    output logic       Data_valid_o,
    output logic       Frame_error_o,
    output logic       Parity_error_o,
    output logic       cm_or_inch_o,
    output logic       Measure_req_o
);

    localparam logic [CNT_W-1:0] bit_last  = CNT_W'(CLKS_PER_BIT_P - 1);
    localparam logic [CNT_W-1:0] half_last = CNT_W'(HALF_BIT_P - 1);
    localparam logic [2:0]       last_idx  = 3'(DATA_BITS_P - 1);

    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             unit_q, unit_d;
    logic             meas_q, meas_d;
    logic             good_byte;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    uart_rx_bit_sync u_sync (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .async_i (Rx_i),
        .sync_o  (rx_s)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        unit_d    = unit_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        meas_d    = 1'b0;
        good_byte = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == half_last) begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == bit_last) begin
                cnt_d     = '0;
                shift_d   = {rx_s, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx_q == last_idx) state_d = RX_PARITY;
`else
                if (bit_idx_q == last_idx) state_d = RX_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: if (cnt_q == bit_last) begin
                cnt_d   = '0;
                par_d   = rx_s;
                state_d = RX_STOP;
            end
`endif
            // Leaving mid stop bit gives half a bit of slack to catch the next start edge.
            RX_STOP: if (cnt_q == bit_last) begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (^{shift_q, par_q}) perr_d = 1'b1;
                    else                   good_byte = 1'b1;
`else
                    good_byte = 1'b1;
`endif
                end else begin
                    ferr_d  = 1'b1;
                    state_d = RX_BREAK;
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = RX_IDLE;
            end
            default: begin
                state_d   = RX_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase

        if (good_byte) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            case (decode_cmd(shift_q))
                CMD_CM:   unit_d = 1'b0;
                CMD_INCH: unit_d = 1'b1;
                CMD_MEAS: meas_d = 1'b1;
                default:  ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            unit_q    <= 1'b0;
            meas_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            unit_q    <= unit_d;
            meas_q    <= meas_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign Data_o        = data_q;
    assign Data_valid_o  = valid_q;
    assign Frame_error_o = ferr_q;
    assign cm_or_inch_o  = unit_q;
    assign Measure_req_o = meas_q;
`ifdef UART_RX_PARITY_EN
    assign Parity_error_o = perr_q;
`else
    assign Parity_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ultrasonic_sensor_uart_receiver.sv
// Self-checking bench for ultrasonic_sensor_uart_receiver, run with a short
// bit period; honours UART_RX_PARITY_EN the same way the design does.
module tb_ultrasonic_sensor_uart_receiver;

    localparam int CPB = 32;
    localparam int HALF = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Rx fall -> 2 sync flops -> IDLE decision -> half bit -> data(+parity)+stop bits.
    localparam int LAT = 3 + HALF + (9 + PB) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, ferr_o, perr_o, unit_o, meas_o;

    ultrasonic_sensor_uart_receiver #(.CLKS_PER_BIT_P(CPB), .HALF_BIT_P(HALF)) dut (
        .Clk_i          (clk),
        .Reset_i        (rst),
        .Rx_i           (rx),
        .Data_o         (data_o),
        .Data_valid_o   (valid_o),
        .Frame_error_o  (ferr_o),
        .Parity_error_o (perr_o),
        .cm_or_inch_o   (unit_o),
        .Measure_req_o  (meas_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_meas = 0;
    logic [7:0] data_q[$];
    int vcyc_q[$];
    int fcyc_q[$];
    int mcyc_q[$];

    always @(negedge clk) begin
        if (valid_o) begin n_valid++; data_q.push_back(data_o); vcyc_q.push_back(cyc); end
        if (ferr_o)  begin n_ferr++;  fcyc_q.push_back(cyc); end
        if (perr_o)  n_perr++;
        if (meas_o)  begin n_meas++;  mcyc_q.push_back(cyc); end
    end

    function automatic logic model_unit(input logic u, input logic [7:0] b);
        if (b == 8'h63 || b == 8'h43) return 1'b0;
        if (b == 8'h69 || b == 8'h49) return 1'b1;
        return u;
    endfunction

    function automatic bit model_meas(input logic [7:0] b);
        return (b == 8'h6D || b == 8'h4D);
    endfunction

    task automatic clear_log();
        data_q.delete(); vcyc_q.delete(); fcyc_q.delete(); mcyc_q.delete();
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip, output int fall);
        fall = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (PB == 1) drive_bit((^b) ^ par_flip, CPB);
        drive_bit(stop_v, CPB);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (ferr_o !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr_o); end
        checks++; if (perr_o !== 1'b0)  begin errors++; $display("FAIL reset_perr: got %b want 0", perr_o); end
        checks++; if (unit_o !== 1'b0)  begin errors++; $display("FAIL reset_unit: got %b want 0", unit_o); end
        checks++; if (meas_o !== 1'b0)  begin errors++; $display("FAIL reset_meas: got %b want 0", meas_o); end
        rst = 1'b0;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_unit_inch();
        int f;
        clear_log();
        send_frame(8'h69, 1'b1, 1'b0, f);
        drive_bit(1'b1, 4);
        checks++; if (data_q.size() != 1) begin errors++; $display("FAIL inch_count: got %0d want 1", data_q.size()); end
        checks++; if (data_o !== 8'h69) begin errors++; $display("FAIL inch_data: got %h want 69", data_o); end
        checks++; if (vcyc_q.size() == 0 || vcyc_q[0] != f + LAT)
            begin errors++; $display("FAIL inch_latency: got %0d want %0d", vcyc_q.size() ? vcyc_q[0] - f : -1, LAT); end
        checks++; if (unit_o !== 1'b1) begin errors++; $display("FAIL inch_unit: got %b want 1", unit_o); end
        checks++; if (fcyc_q.size() != 0) begin errors++; $display("FAIL inch_ferr: got %0d want 0", fcyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        int f [3];
        seq[0] = 8'h63; seq[1] = 8'h6D; seq[2] = 8'h78;
        clear_log();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, 1'b0, f[i]);
        drive_bit(1'b1, 4);
        checks++; if (data_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", data_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_q.size() > i && data_q[i] !== seq[i])
                begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, data_q[i], seq[i]); end
            checks++; if (vcyc_q.size() > i && vcyc_q[i] != f[i] + LAT)
                begin errors++; $display("FAIL b2b_latency%0d: got %0d want %0d", i, vcyc_q[i] - f[i], LAT); end
        end
        checks++; if (mcyc_q.size() != 1) begin errors++; $display("FAIL b2b_meas_count: got %0d want 1", mcyc_q.size()); end
        checks++; if (mcyc_q.size() == 1 && mcyc_q[0] != f[1] + LAT)
            begin errors++; $display("FAIL b2b_meas_cycle: got %0d want %0d", mcyc_q[0], f[1] + LAT); end
        checks++; if (unit_o !== 1'b0) begin errors++; $display("FAIL b2b_unit: got %b want 0", unit_o); end
    endtask

    task automatic test_glitch();
        int f;
        clear_log();
        drive_bit(1'b0, HALF - 10);
        drive_bit(1'b1, 3 * CPB);
        checks++; if (data_q.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", data_q.size()); end
        checks++; if (fcyc_q.size() != 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", fcyc_q.size()); end
        send_frame(8'h49, 1'b1, 1'b0, f);
        drive_bit(1'b1, 4);
        checks++; if (vcyc_q.size() != 1 || vcyc_q[0] != f + LAT)
            begin errors++; $display("FAIL glitch_recover: got %0d pulses want 1 at +%0d", vcyc_q.size(), LAT); end
        checks++; if (data_o !== 8'h49 || unit_o !== 1'b1)
            begin errors++; $display("FAIL glitch_after: got %h/%b want 49/1", data_o, unit_o); end
    endtask

    task automatic test_break();
        int f;
        clear_log();
        send_frame(8'h4D, 1'b0, 1'b0, f);
        drive_bit(1'b0, 2000);
        checks++; if (data_q.size() != 0) begin errors++; $display("FAIL break_valid: got %0d want 0", data_q.size()); end
        checks++; if (fcyc_q.size() != 1 || fcyc_q[0] != f + LAT)
            begin errors++; $display("FAIL break_ferr: got %0d pulses want 1 at +%0d", fcyc_q.size(), LAT); end
        checks++; if (mcyc_q.size() != 0) begin errors++; $display("FAIL break_meas: got %0d want 0", mcyc_q.size()); end
        checks++; if (data_o !== 8'h49) begin errors++; $display("FAIL break_data_held: got %h want 49", data_o); end
        drive_bit(1'b1, CPB);
        send_frame(8'h4D, 1'b1, 1'b0, f);
        drive_bit(1'b1, 4);
        checks++; if (vcyc_q.size() != 1 || data_o !== 8'h4D)
            begin errors++; $display("FAIL break_M: got %0d pulses data %h want 1 / 4d", vcyc_q.size(), data_o); end
        checks++; if (mcyc_q.size() != 1) begin errors++; $display("FAIL break_M_meas: got %0d want 1", mcyc_q.size()); end
        checks++; if (fcyc_q.size() != 1) begin errors++; $display("FAIL break_ferr_total: got %0d want 1", fcyc_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int f;
        b = 8'h49;
        clear_log();
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], CPB / 2);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (data_o !== 8'h00 || unit_o !== 1'b0 || valid_o !== 1'b0)
            begin errors++; $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", data_o, unit_o, valid_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b1, 2 * CPB);
        checks++; if (data_q.size() != 0 || fcyc_q.size() != 0)
            begin errors++; $display("FAIL midreset_abort: got %0d valid %0d ferr want 0/0", data_q.size(), fcyc_q.size()); end
        send_frame(8'h63, 1'b1, 1'b0, f);
        drive_bit(1'b1, 4);
        checks++; if (data_q.size() != 1 || data_o !== 8'h63)
            begin errors++; $display("FAIL midreset_next: got %0d pulses data %h want 1 / 63", data_q.size(), data_o); end
        checks++; if (unit_o !== 1'b0) begin errors++; $display("FAIL midreset_unit: got %b want 0", unit_o); end
    endtask

    task automatic test_random(inout logic exp_unit);
        logic [7:0] cmds [6];
        logic [7:0] b;
        int f, gap, exp_meas;
        cmds[0] = 8'h63; cmds[1] = 8'h43; cmds[2] = 8'h69;
        cmds[3] = 8'h49; cmds[4] = 8'h6D; cmds[5] = 8'h4D;
        exp_meas = 0;
        for (int n = 0; n < 8; n++) begin
            clear_log();
            if ($urandom_range(0, 1) == 1) b = cmds[$urandom_range(0, 5)];
            else                           b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, CPB);
            if (gap > 0) drive_bit(1'b1, gap);
            send_frame(b, 1'b1, 1'b0, f);
            exp_unit = model_unit(exp_unit, b);
            if (model_meas(b)) exp_meas++;
            checks++; if (data_q.size() != 1 || data_q[0] !== b)
                begin errors++; $display("FAIL rand%0d_data: got %0d pulses data %h want %h", n, data_q.size(), data_o, b); end
            checks++; if (vcyc_q.size() != 1 || vcyc_q[0] != f + LAT)
                begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, vcyc_q.size() ? vcyc_q[0] - f : -1, LAT); end
            checks++; if (unit_o !== exp_unit)
                begin errors++; $display("FAIL rand%0d_unit: got %b want %b (byte %h)", n, unit_o, exp_unit, b); end
            checks++; if (mcyc_q.size() != (model_meas(b) ? 1 : 0))
                begin errors++; $display("FAIL rand%0d_meas: got %0d for byte %h", n, mcyc_q.size(), b); end
        end
        drive_bit(1'b1, 4);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int f, p0;
        send_frame(8'h63, 1'b1, 1'b0, f);
        clear_log();
        p0 = n_perr;
        send_frame(8'h69, 1'b1, 1'b1, f);
        drive_bit(1'b1, 4);
        checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL parity_err: got %0d pulses want 1", n_perr - p0); end
        checks++; if (data_q.size() != 0) begin errors++; $display("FAIL parity_valid: got %0d want 0", data_q.size()); end
        checks++; if (unit_o !== 1'b0) begin errors++; $display("FAIL parity_unit_held: got %b want 0", unit_o); end
        send_frame(8'h69, 1'b1, 1'b0, f);
        drive_bit(1'b1, 4);
        checks++; if (data_q.size() != 1 || data_o !== 8'h69)
            begin errors++; $display("FAIL parity_good: got %0d pulses data %h want 1 / 69", data_q.size(), data_o); end
        checks++; if (unit_o !== 1'b1) begin errors++; $display("FAIL parity_unit: got %b want 1", unit_o); end
        checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL parity_no_extra: got %0d want 1", n_perr - p0); end
    endtask
`endif

    initial begin
        logic unit_model;
        test_reset();
        test_unit_inch();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        unit_model = 1'b0;
        test_random(unit_model);
`ifdef UART_RX_PARITY_EN
        test_parity();
`else
        checks++; if (n_perr != 0) begin errors++; $display("FAIL parity_tied: got %0d pulses want 0", n_perr); end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
